// File: rtl/adder_pkg.sv
// Shared types for the multi-cycle add/subtract unit: FSM state encoding and op codes.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-bit combinational ripple slice; zero latency, no handshake.
// c_msb is the carry into the top bit so the caller can form signed overflow.
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    always_comb begin : ripple
        logic cy;
        cy    = cin;
        s     = '0;
        c_msb = cin;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                c_msb = cy;
            end
            s[i] = a[i] ^ b[i] ^ cy;
            cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        cout = cy;
    end

endmodule

// File: rtl/adder_nbits_seq.sv
// Multi-cycle WIDTH-bit add/sub, CHUNK bits per clock; out_valid WIDTH/CHUNK edges after accept.
// One op in flight; result held until out_ready. ADDER_SAT_EN enables signed saturation.
module adder_nbits_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             flagN,
    output logic             flagZ,
    output logic             flagC,
    output logic             flagV
);

    localparam int STEPS = WIDTH / CHUNK;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

    if ((WIDTH % CHUNK) != 0 || WIDTH < 2) begin : g_bad_cfg
        $error("adder_nbits_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end

`ifdef ADDER_SAT_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [SW-1:0]    step_q, step_d;
    logic             carry_q, carry_d;
    logic             out_valid_q, out_valid_d;
    logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;

    logic [CHUNK-1:0]       slice_s;
    logic                   slice_cout;
    logic                   slice_cmsb;
    logic [WIDTH+CHUNK-1:0] res_wide;
    logic [WIDTH-1:0]       res_shift;
    logic [WIDTH-1:0]       sum_fin;
    logic                   raw_v;

    adder_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_q[CHUNK-1:0]),
        .b     (b_q[CHUNK-1:0]),
        .cin   (carry_q),
        .s     (slice_s),
        .cout  (slice_cout),
        .c_msb (slice_cmsb)
    );

    always_comb begin
        // Result fills from the top so that after STEPS shifts chunk 0 sits at the LSBs.
        res_wide  = {slice_s, res_q};
        res_shift = res_wide[WIDTH+CHUNK-1:CHUNK];
        raw_v     = slice_cmsb ^ slice_cout;
        sum_fin   = res_shift;
`ifdef ADDER_SAT_EN
        // A wrapped-negative raw MSB on overflow means the true result was positive.
        if (raw_v) begin
            sum_fin = slice_s[CHUNK-1] ? SAT_POS : SAT_NEG;
        end
`endif

        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        sum_d       = sum_q;
        step_d      = step_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;
        n_d         = n_q;
        z_d         = z_q;
        c_d         = c_q;
        v_d         = v_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = (op == OP_SUB) ? ~B : B;
                    carry_d = (op == OP_SUB);
                    res_d   = '0;
                    step_d  = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = slice_cout;
                res_d   = res_shift;
                step_d  = step_q + 1'b1;
                if (step_q == LAST_STEP) begin
                    state_d     = DONE;
                    sum_d       = sum_fin;
                    n_d         = sum_fin[WIDTH-1];
                    z_d         = (sum_fin == '0);
                    c_d         = slice_cout;
                    v_d         = raw_v;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            sum_q       <= '0;
            step_q      <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            sum_q       <= sum_d;
            step_q      <= step_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            n_q         <= n_d;
            z_q         <= z_d;
            c_q         <= c_d;
            v_q         <= v_d;
        end
    end

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = out_valid_q;
    assign Sum       = sum_q;
    assign flagN     = n_q;
    assign flagZ     = z_q;
    assign flagC     = c_q;
    assign flagV     = v_q;

endmodule
